gap_accumulate_writer: RTL and testbench
========================================

Name: gap_accumulate_writer

Overview:
- Global-average-pooling front end for the squeeze-excitation path.
- Consumes a channel-grouped activation stream, sums HxW pixels per 4-channel group and scales by a reciprocal.
- Writes one 32-bit word of four int8 averages per group into the pooling BRAM through its single write port (write enable, write address, write data).
- The SE stage later reads four consecutive words (16 channels) from that BRAM.

Parameters:
- LANES, 4, int8 channels per beat/word; DATA_WIDTH = 8*LANES.
- ACC_W, 24, signed accumulator width per lane; sized so 65535 pixels of ±128 never overflow.
- ADDR_W, 32, BRAM write address width.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle pulse; latches cfg_* and begins a job; ignored while busy
- cfg_num_pixels  input  16  pixels per group (H*W)
- cfg_num_groups  input  12  channel groups (C/LANES)
- cfg_recip  input  16  unsigned Q0.16 of 1/H*W
- cfg_base_addr  input  ADDR_W  BRAM word address of group 0
- in_valid  input  1  in_data valid
- in_ready  output  1  block accepts a beat; transfer when in_valid&&in_ready
- in_data  input  DATA_WIDTH  lane k = signed int8 at [8k+7:8k], one pixel of current group
- wr_rd_en  output  1  BRAM write strobe
- wr_addr  output  ADDR_W  BRAM write address
- wr_data  output  DATA_WIDTH  averaged lanes, same packing as in_data
- busy  output  1  job in progress
- done  output  1  one-cycle pulse, job complete

Behaviour:
- Reset: state IDLE. in_ready, wr_rd_en, busy and done are 0. wr_addr, wr_data, accumulators and counters are 0. Effective immediately, including mid-job; no partial write is issued afterwards.
- FSM: IDLE -> ACC -> SCALE -> WRITE -> (ACC | FIN) -> IDLE.
- IDLE: in_ready=0, busy=0.
  - start: latch cfg, clear accumulators, pix_cnt=0, grp_cnt=0.
  - If cfg_num_pixels==0 or cfg_num_groups==0: go to FIN (no writes). Else go to ACC.
- ACC: in_ready=1, busy=1.
  - Each accepted beat: acc[k] += sign-extended lane k, pix_cnt++.
  - Beat with pix_cnt==num_pixels-1: go to SCALE.
  - in_valid low stalls with no state change.
- SCALE (1 cycle): in_ready=0. Per lane:
  - p = acc[k]*recip (signed x unsigned, 41-bit).
  - r = (p + 2^15) >>> 16, i.e. round half up toward +inf.
  - Saturate r to [-128,127] and register into wr_data.
  - wr_addr <= base + grp_cnt, modulo 2^ADDR_W.
- WRITE (1 cycle): wr_rd_en=1 with stable wr_addr/wr_data. Then clear accumulators and pix_cnt, grp_cnt++.
  - Next state: ACC if grp_cnt+1 < num_groups, else FIN.
- FIN (1 cycle): done=1, busy=1, then IDLE.
- Latency: last beat of a group accepted at cycle t -> wr_rd_en high at t+2. After the final group, done high at t+3.
- Throughput: 1 beat/cycle inside a group, 2 bubble cycles per group.
- wr_rd_en is high only in WRITE. wr_addr/wr_data hold their last values otherwise.
- start while busy: ignored. in_valid outside ACC: not accepted.
- cfg_* changes mid-job: no effect; latched copies are used.

Decomposition:
- Shared package: state enum (IDLE/ACC/SCALE/WRITE/FIN), LANES, RECIP_FRAC=16, INT8_MIN/INT8_MAX.
- One natural sub-module: gap_lane_scale. It does the combinational multiply, round and saturate for one lane, instantiated LANES times. The FSM, counters and accumulators stay in the top.

Test Plan:
- Basic average: pixels=4, groups=1, recip=16384, base=0. Lanes over 4 beats are lane0 {10,20,30,40}, lane1 all -128, lane2 {1,2,2,2}, lane3 all 127. Required: single write at addr 0, lanes {25,-128,2,127} (wr_data=0x7F02_8019), done one cycle after write.
- Saturation: pixels=4, recip=32768. lane0 all 100, lane1 all -100, lanes 2/3 all 0. Required: lanes {127,-128,0,0}.
- Multi-group/addressing: pixels=2, groups=3, base=0x10, all beats lane value = group index. Required:
  - exactly three writes at 0x10, 0x11, 0x12;
  - wr_rd_en exactly 2 cycles after each group's last beat;
  - busy high throughout, done once.
- Backpressure/stall: in_valid toggled randomly 50% during pixels=8 job, recip=8192. Required: identical wr_data to the unstalled run; in_ready low in SCALE/WRITE/FIN.
- Degenerate config and start-while-busy: pixels=0, groups=5. Required: no wr_rd_en, done 2 cycles after start. Second start pulse mid-job: ignored, single done.
- Reset mid-operation: assert rst_n=0 after 3 of 4 beats. Required: all outputs 0 asynchronously; no write afterwards. A fresh job after release produces correct results from cleared accumulators.

Source files
------------

// File: rtl/gap_accumulate_writer_pkg.sv
// -----------------------------------------------------------------------------
// gap_accumulate_writer_pkg
// Shared definitions for the global-average-pooling writer:
//   - state_t    : controller states (IDLE/ACC/SCALE/WRITE/FIN)
//   - LANES      : int8 channels per beat and per BRAM word
//   - RECIP_FRAC : fractional bits of the Q0.16 reciprocal
//   - INT8_MIN/MAX : saturation bounds of an averaged lane
// -----------------------------------------------------------------------------
package gap_accumulate_writer_pkg;

    localparam int LANES      = 4;
    localparam int RECIP_FRAC = 16;
    localparam int INT8_MIN   = -128;
    localparam int INT8_MAX   = 127;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ACC   = 3'd1,
        ST_SCALE = 3'd2,
        ST_WRITE = 3'd3,
        ST_FIN   = 3'd4
    } state_t;

endpackage : gap_accumulate_writer_pkg

// File: rtl/gap_accumulate_writer_lane_scale.sv
// -----------------------------------------------------------------------------
// gap_lane_scale
// Combinational scale of one lane's pixel sum into an int8 average:
//   avg = sat_int8( (acc * recip + 2^15) >>> 16 )
// i.e. a signed-by-unsigned Q0.16 multiply, round half up toward +inf, then
// clamp to [-128, 127].
// Ports:
//   acc   in  ACC_W  signed pixel sum of the lane
//   recip in  16     unsigned Q0.16 reciprocal of the pixel count
//   avg   out 8      signed int8 average (two's complement bit pattern)
// -----------------------------------------------------------------------------
module gap_lane_scale #(
    parameter int ACC_W = 24
) (
    input  logic signed [ACC_W-1:0] acc,
    input  logic        [15:0]      recip,
    output logic        [7:0]       avg
);
    import gap_accumulate_writer_pkg::*;

    // ACC_W signed bits times a 17-bit non-negative value fits in ACC_W+17 bits.
    localparam int P_W = ACC_W + 17;

    localparam logic signed [P_W-1:0] HALF   = P_W'(1) << (RECIP_FRAC - 1);
    localparam logic signed [P_W-1:0] SAT_HI = P_W'(INT8_MAX);
    localparam logic signed [P_W-1:0] SAT_LO = P_W'(INT8_MIN);

    logic signed [P_W-1:0] prod;
    logic signed [P_W-1:0] rounded;

    // NOTE: every signal written here gets a value on every path, so no latch is inferred.
    always_comb begin
        // Zero-extend recip so the multiply treats it as unsigned.
        prod    = $signed({{17{acc[ACC_W-1]}}, acc}) * $signed({{(P_W-16){1'b0}}, recip});
        // Arithmetic shift floors, so adding one half first rounds half up.
        rounded = (prod + HALF) >>> RECIP_FRAC;
        if (rounded > SAT_HI) begin
            avg = 8'(INT8_MAX);
        end else if (rounded < SAT_LO) begin
            avg = 8'(INT8_MIN);
        end else begin
            avg = rounded[7:0];
        end
    end

endmodule : gap_lane_scale

// File: rtl/gap_accumulate_writer.sv
// -----------------------------------------------------------------------------
// gap_accumulate_writer
// Global-average-pooling front end for the squeeze-excitation path. Sums
// num_pixels beats per 4-channel group, scales each lane sum by a Q0.16
// reciprocal and writes one word of LANES int8 averages per group to the
// pooling BRAM at base + group index.
// Ports:
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   start             one-cycle job start; ignored while busy
//   cfg_num_pixels    pixels per group (H*W), latched at start
//   cfg_num_groups    channel groups (C/LANES), latched at start
//   cfg_recip         unsigned Q0.16 of 1/(H*W), latched at start
//   cfg_base_addr     BRAM word address of group 0, latched at start
//   in_valid/in_ready/in_data  activation beat handshake, lane k at [8k+7:8k]
//   wr_rd_en/wr_addr/wr_data   BRAM write port (strobe high for one cycle)
//   busy              job in progress
//   done              one-cycle pulse when the job completes
// -----------------------------------------------------------------------------
module gap_accumulate_writer #(
    parameter  int LANES      = gap_accumulate_writer_pkg::LANES,
    parameter  int ACC_W      = 24,
    parameter  int ADDR_W     = 32,
    localparam int DATA_WIDTH = 8 * LANES
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [15:0]           cfg_num_pixels,
    input  logic [11:0]           cfg_num_groups,
    input  logic [15:0]           cfg_recip,
    input  logic [ADDR_W-1:0]     cfg_base_addr,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  wr_rd_en,
    output logic [ADDR_W-1:0]     wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  busy,
    output logic                  done
);
    import gap_accumulate_writer_pkg::*;

    state_t                  state;

    // Configuration captured at start; cfg_* may change freely mid-job.
    logic [15:0]             num_pixels_q;
    logic [11:0]             num_groups_q;
    logic [15:0]             recip_q;
    logic [ADDR_W-1:0]       base_q;

    logic [15:0]             pix_cnt;
    logic [11:0]             grp_cnt;
    logic signed [ACC_W-1:0] acc [LANES];

    logic [DATA_WIDTH-1:0]   avg_word;
    logic                    beat;
    logic                    last_beat;
    logic                    more_groups;

    assign beat        = in_valid && in_ready;
    assign last_beat   = (pix_cnt == num_pixels_q - 16'd1);
    // Widened by one bit so grp_cnt+1 cannot wrap before the compare.
    assign more_groups = ({1'b0, grp_cnt} + 13'd1) < {1'b0, num_groups_q};

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        gap_lane_scale #(
            .ACC_W (ACC_W)
        ) u_lane_scale (
            .acc   (acc[k]),
            .recip (recip_q),
            .avg   (avg_word[8*k +: 8])
        );
    end

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            num_pixels_q <= '0;
            num_groups_q <= '0;
            recip_q      <= '0;
            base_q       <= '0;
            pix_cnt      <= '0;
            grp_cnt      <= '0;
            in_ready     <= 1'b0;
            wr_rd_en     <= 1'b0;
            wr_addr      <= '0;
            wr_data      <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            // NOTE: the accumulator array is a small register file, not a RAM, so it is reset like any flop.
            for (int k = 0; k < LANES; k++) begin
                acc[k] <= '0;
            end
        end else begin
            // Strobes default low; only the states below raise them.
            wr_rd_en <= 1'b0;
            done     <= 1'b0;

            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        num_pixels_q <= cfg_num_pixels;
                        num_groups_q <= cfg_num_groups;
                        recip_q      <= cfg_recip;
                        base_q       <= cfg_base_addr;
                        pix_cnt      <= '0;
                        grp_cnt      <= '0;
                        busy         <= 1'b1;
                        for (int k = 0; k < LANES; k++) begin
                            acc[k] <= '0;
                        end
                        if (cfg_num_pixels == 16'd0 || cfg_num_groups == 12'd0) begin
                            state <= ST_FIN;
                            done  <= 1'b1;
                        end else begin
                            state    <= ST_ACC;
                            in_ready <= 1'b1;
                        end
                    end
                end

                ST_ACC: begin
                    if (beat) begin
                        for (int k = 0; k < LANES; k++) begin
                            acc[k] <= acc[k] + {{(ACC_W-8){in_data[8*k+7]}}, in_data[8*k +: 8]};
                        end
                        pix_cnt <= pix_cnt + 16'd1;
                        if (last_beat) begin
                            state    <= ST_SCALE;
                            in_ready <= 1'b0;
                        end
                    end
                end

                ST_SCALE: begin
                    // Accumulators are final here; capture the scaled word and its address.
                    wr_data  <= avg_word;
                    wr_addr  <= base_q + ADDR_W'(grp_cnt);
                    wr_rd_en <= 1'b1;
                    state    <= ST_WRITE;
                end

                ST_WRITE: begin
                    pix_cnt <= '0;
                    grp_cnt <= grp_cnt + 12'd1;
                    for (int k = 0; k < LANES; k++) begin
                        acc[k] <= '0;
                    end
                    if (more_groups) begin
                        state    <= ST_ACC;
                        in_ready <= 1'b1;
                    end else begin
                        state <= ST_FIN;
                        done  <= 1'b1;
                    end
                end

                ST_FIN: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end

                default: begin
                    state    <= ST_IDLE;
                    in_ready <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule : gap_accumulate_writer

// File: tb/tb_gap_accumulate_writer.sv
// -----------------------------------------------------------------------------
// tb_gap_accumulate_writer
// Self-checking bench: the driver computes each group's expected word with a
// behavioural average model and pushes {addr, data, cycle} to a scoreboard;
// a negedge monitor pops and compares on every BRAM write.
// -----------------------------------------------------------------------------
module tb_gap_accumulate_writer;

    localparam int LANES  = 4;
    localparam int ADDR_W = 32;
    localparam int DW     = 8 * LANES;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [15:0]       cfg_num_pixels;
    logic [11:0]       cfg_num_groups;
    logic [15:0]       cfg_recip;
    logic [ADDR_W-1:0] cfg_base_addr;
    logic              in_valid;
    logic              in_ready;
    logic [DW-1:0]     in_data;
    logic              wr_rd_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DW-1:0]     wr_data;
    logic              busy;
    logic              done;

    gap_accumulate_writer #(
        .LANES  (LANES),
        .ACC_W  (24),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .cfg_num_pixels (cfg_num_pixels),
        .cfg_num_groups (cfg_num_groups),
        .cfg_recip      (cfg_recip),
        .cfg_base_addr  (cfg_base_addr),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_data        (in_data),
        .wr_rd_en       (wr_rd_en),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .busy           (busy),
        .done           (done)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          cyc;
    } wr_exp_t;

    wr_exp_t     sb[$];
    logic [31:0] beat_q[$];
    wr_exp_t     mon_e;

    int          checks        = 0;
    int          failures      = 0;
    int          cyc           = 0;
    int          done_cnt      = 0;
    int          last_done_cyc = -1;
    int          write_cnt     = 0;
    int          busy_low      = 0;
    bit          job_active    = 1'b0;
    logic        prev_in_ready = 1'b0;
    logic [31:0] last_wr_data  = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Write/done monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (wr_rd_en) begin
                write_cnt++;
                last_wr_data = wr_data;
                check("in_ready_low_in_write", in_ready, 0);
                check("in_ready_low_in_scale", prev_in_ready, 0);
                check("write_expected", sb.size() > 0, 1);
                if (sb.size() > 0) begin
                    mon_e = sb.pop_front();
                    check("wr_addr", wr_addr, mon_e.addr);
                    check("wr_data", wr_data, mon_e.data);
                    check("wr_latency", cyc, mon_e.cyc);
                end
            end
            if (done) begin
                done_cnt++;
                last_done_cyc = cyc;
                check("in_ready_low_in_fin", in_ready, 0);
                check("busy_in_fin", busy, 1);
                job_active = 1'b0;
            end
            if (job_active && !busy) busy_low++;
        end
        prev_in_ready = in_ready;
    end

    function automatic logic [7:0] avg_model(input int sum, input int recip);
        longint p;
        longint r;
        p = longint'(sum) * longint'(recip);
        r = (p + 64'sd32768) >>> 16;
        if (r > 127)  return 8'h7f;
        if (r < -128) return 8'h80;
        return 8'(r);
    endfunction

    function automatic logic [31:0] pack4(input int l0, input int l1, input int l2, input int l3);
        return {8'(l3), 8'(l2), 8'(l1), 8'(l0)};
    endfunction

    // Presents one beat (optionally with random bubbles) until it is accepted.
    // t is the cycle index of the accepting cycle, -1 if it never was.
    task automatic send_beat(input logic [31:0] d, input bit stall, output int t);
        int tries;
        tries = 0;
        t     = -1;
        while (t < 0 && tries < 200) begin
            tries++;
            if (stall && $urandom_range(1, 0) == 1) begin
                in_valid = 1'b0;
                in_data  = $urandom;
                @(negedge clk);
            end else begin
                in_valid = 1'b1;
                in_data  = d;
                if (in_ready) t = cyc;
                @(negedge clk);
            end
        end
        check("beat_accepted", t >= 0, 1);
    endtask

    task automatic run_job(input int pixels, input int groups, input int recip,
                           input logic [31:0] base, input bit stall, input bit poke_start);
        int          t;
        int          last_t;
        int          start_cyc;
        int          done_before;
        int          waitc;
        int          sums[LANES];
        logic [31:0] beat;
        logic [31:0] word;

        done_before    = done_cnt;
        cfg_num_pixels = 16'(pixels);
        cfg_num_groups = 12'(groups);
        cfg_recip      = 16'(recip);
        cfg_base_addr  = base;
        start          = 1'b1;
        start_cyc      = cyc;
        @(negedge clk);
        start      = 1'b0;
        busy_low   = 0;
        job_active = 1'b1;
        last_t     = -1;

        if (pixels != 0 && groups != 0) begin
            for (int g = 0; g < groups; g++) begin
                for (int k = 0; k < LANES; k++) sums[k] = 0;
                for (int p = 0; p < pixels; p++) begin
                    beat = beat_q.pop_front();
                    for (int k = 0; k < LANES; k++) sums[k] += int'($signed(beat[8*k +: 8]));
                    send_beat(beat, stall, t);
                    last_t = t;
                end
                for (int k = 0; k < LANES; k++) word[8*k +: 8] = avg_model(sums[k], recip);
                sb.push_back('{addr: base + 32'(g), data: word, cyc: last_t + 2});
                if (poke_start && g == 0) begin
                    // Start pulse with a different config while busy: must be ignored.
                    start          = 1'b1;
                    cfg_num_pixels = 16'd0;
                    cfg_base_addr  = 32'hdead_0000;
                    @(negedge clk);
                    start = 1'b0;
                end
            end
        end
        in_valid = 1'b0;

        waitc = 0;
        while (done_cnt == done_before && waitc < 60) begin
            @(negedge clk);
            waitc++;
        end
        repeat (4) @(negedge clk);
        check("done_once", done_cnt - done_before, 1);
        if (pixels == 0 || groups == 0)
            check("degenerate_done_latency", (last_done_cyc - start_cyc) inside {[1:2]}, 1);
        else
            check("done_latency", last_done_cyc, last_t + 3);
        check("scoreboard_drained", sb.size(), 0);
        if (groups > 1) check("busy_throughout", busy_low, 0);
        job_active = 1'b0;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_wr_rd_en"}, wr_rd_en, 0);
        check({tag, "_busy"},     busy,     0);
        check({tag, "_done"},     done,     0);
        check({tag, "_wr_addr"},  wr_addr,  0);
        check({tag, "_wr_data"},  wr_data,  0);
    endtask

    initial begin
        int          t;
        int          wc;
        logic [31:0] rnd[8];
        logic [31:0] d_unstalled;

        rst_n          = 1'b0;
        start          = 1'b0;
        cfg_num_pixels = '0;
        cfg_num_groups = '0;
        cfg_recip      = '0;
        cfg_base_addr  = '0;
        in_valid       = 1'b0;
        in_data        = '0;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Basic average.
        beat_q.push_back(pack4(10, -128, 1, 127));
        beat_q.push_back(pack4(20, -128, 2, 127));
        beat_q.push_back(pack4(30, -128, 2, 127));
        beat_q.push_back(pack4(40, -128, 2, 127));
        run_job(4, 1, 16384, 32'h0, 1'b0, 1'b0);
        check("basic_word", last_wr_data, 32'h7F02_8019);

        // Saturation.
        repeat (4) beat_q.push_back(pack4(100, -100, 0, 0));
        run_job(4, 1, 32768, 32'h4, 1'b0, 1'b0);
        check("saturate_word", last_wr_data, 32'h0000_807F);

        // Multi-group addressing, with an ignored start mid-job.
        wc = write_cnt;
        for (int g = 0; g < 3; g++) repeat (2) beat_q.push_back(pack4(g, g, g, g));
        run_job(2, 3, 32768, 32'h10, 1'b0, 1'b1);
        check("multi_group_writes", write_cnt - wc, 3);

        // Backpressure: same data unstalled, then with random bubbles.
        for (int i = 0; i < 8; i++)
            rnd[i] = pack4($urandom_range(100, 20), -int'($urandom_range(90, 10)),
                           $urandom_range(127, 0), -int'($urandom_range(128, 0)));
        for (int i = 0; i < 8; i++) beat_q.push_back(rnd[i]);
        run_job(8, 1, 8192, 32'h20, 1'b0, 1'b0);
        d_unstalled = last_wr_data;
        for (int i = 0; i < 8; i++) beat_q.push_back(rnd[i]);
        run_job(8, 1, 8192, 32'h20, 1'b1, 1'b0);
        check("stalled_matches_unstalled", last_wr_data, d_unstalled);

        // Degenerate configuration: no writes, single done.
        wc = write_cnt;
        run_job(0, 5, 16384, 32'h30, 1'b0, 1'b0);
        check("degenerate_no_write", write_cnt - wc, 0);

        // Reset after 3 of 4 beats.
        cfg_num_pixels = 16'd4;
        cfg_num_groups = 12'd1;
        cfg_recip      = 16'd16384;
        cfg_base_addr  = 32'h40;
        start          = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) send_beat(pack4(50, 50, 50, 50), 1'b0, t);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        check_outputs_zero("async_reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wc    = write_cnt;
        repeat (10) @(negedge clk);
        check("no_write_after_reset", write_cnt - wc, 0);

        // Fresh job after reset.
        repeat (4) beat_q.push_back(pack4(4, 8, -4, 0));
        run_job(4, 1, 16384, 32'h40, 1'b0, 1'b0);
        check("post_reset_word", last_wr_data, 32'h00FC_0804);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog got=timeout exp=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_gap_accumulate_writer
